mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//   M-stage data-SRAM access unit, directly downstream of the store-data replicator.
//   Turns op/address/replicated store data into data-SRAM enable, byte write-enables and address.
//   Flags address errors (AdEL/AdES) and aligns/extends load data returned one cycle later for W stage.
//   Holds load data across W-stage stalls.
// PARAMETERS
//   UNMAPPED_MASK  32'h1FFF_FFFF  mask applied to kseg0/kseg1 addresses (addr[31:30]==2'b10)
//   XLATE_EN       1              1: apply UNMAPPED_MASK; 0: pass address through unchanged
// PORTS
//   clk              in   1   core clock
//   rst              in   1   synchronous reset, active-high
//   stall            in   1   pipeline freeze (M->W does not advance)
//   flush            in   1   exception flush; kills M access and pending load
//   valid_m          in   1   M-stage instruction valid
//   op_m             in   8   `EXE_*_OP code of M-stage instruction
//   addr_m           in   32  effective address
//   wdata_m          in   32  store data, already byte/half replicated
//   data_sram_rdata  in   32  SRAM read data, valid the cycle after an enabled read
//   data_sram_en     out  1   SRAM access enable
//   data_sram_wen    out  4   byte write enables
//   data_sram_addr   out  32  physical address
//   data_sram_wdata  out  32  = wdata_m
//   adel_m / ades_m  out  1   load / store address error
//   badvaddr_m       out  32  = addr_m when adel_m|ades_m, else 0
//   readdata_w       out  32  aligned, extended load result for W stage
// BEHAVIOUR
//   - Loads: LB LBU LH LHU LW; stores: SB SH SW; any other op: no access, no exception.
//   - Misalignment: half ops need addr[0]==0; word ops need addr[1:0]==0.
//     Load misaligned -> adel_m; store misaligned -> ades_m.
//     Exceptions are combinational and qualified by valid_m only.
//   - go = valid_m & mem_op & ~adel_m & ~ades_m & ~stall & ~flush.
//     data_sram_en = go; the access fires only on the cycle the instruction advances.
//   - data_sram_wen = 0 unless go & store.
//     SB: 4'b0001<<addr[1:0]; SH: addr[1] ? 4'b1100 : 4'b0011; SW: 4'b1111.
//   - data_sram_addr: if XLATE_EN & addr[31:30]==2'b10 then addr_m & UNMAPPED_MASK, else addr_m.
//   - FSM, all transitions on clk edge:
//     IDLE: go & load -> RESP.
//     RESP (rdata live this cycle):
//       flush -> IDLE;
//       stall -> HOLD, capturing rdata into hold_q;
//       go & load -> RESP;
//       else -> IDLE.
//     HOLD: flush -> IDLE; ~stall & go & load -> RESP; ~stall -> IDLE; else stay.
//   - Registered on every go & load: ld_op_q (op) and ld_off_q (addr[1:0]).
//   - readdata_w source: data_sram_rdata in RESP, hold_q in HOLD, 32'h0 in IDLE.
//     Byte = src[8*off+:8]; half = src[16*off[1]+:16].
//     LB/LH sign-extend, LBU/LHU zero-extend, LW whole word.
//   - Latency: load issued in cycle N -> readdata_w valid in N+1, and stable through any stall.
//   - Reset: state IDLE; hold_q, ld_op_q, ld_off_q = 0.
//     All outputs 0 (data_sram_* follow inputs but en/wen = 0 while rst).
//   - rst or flush while in HOLD: drop held data immediately on the edge; readdata_w = 0 next cycle.
//   - flush and stall together: flush wins.
// TESTING
//   1. SB, addr 0x0000_0102, wdata 0xABAB_ABAB -> en=1, wen=4'b0100, wdata=0xABAB_ABAB.
//   2. LB addr off 3, next-cycle rdata 0x8012_3456 -> readdata_w 0xFFFF_FF80; LBU -> 0x0000_0080.
//   3. LH addr 0x0000_0001 -> adel_m=1, badvaddr_m=0x0000_0001, en=0; SW addr 0x2 -> ades_m=1, wen=0.
//   4. LW 0x10 returns 0xDEAD_BEEF, then stall 3 cycles with rdata=0x0 ->
//      readdata_w stays 0xDEAD_BEEF, then IDLE.
//   5. addr 0xBFC0_0010 -> data_sram_addr 0x1FC0_0010; addr 0x0000_0010 -> 0x0000_0010 unchanged.
//   6. rst or flush asserted in HOLD -> next cycle state IDLE, readdata_w 0, en/wen 0.

Source files
------------

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module      : mem_access_unit
// Description : M-stage data-SRAM access unit. Decodes load/store ops into
//               SRAM enable, byte write-enables and physical address, flags
//               address errors, and aligns/extends the returned load data
//               for W stage, holding it across W-stage stalls.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit #(
    parameter logic [31:0] UNMAPPED_MASK = 32'h1FFF_FFFF,
    parameter bit          XLATE_EN      = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        valid_m,
    input  logic [7:0]  op_m,
    input  logic [31:0] addr_m,
    input  logic [31:0] wdata_m,
    input  logic [31:0] data_sram_rdata,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_wen,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    output logic        adel_m,
    output logic        ades_m,
    output logic [31:0] badvaddr_m,
    output logic [31:0] readdata_w
);

    localparam logic [7:0] C_OP_LB  = 8'b1110_0000;
    localparam logic [7:0] C_OP_LH  = 8'b1110_0001;
    localparam logic [7:0] C_OP_LW  = 8'b1110_0011;
    localparam logic [7:0] C_OP_LBU = 8'b1110_0100;
    localparam logic [7:0] C_OP_LHU = 8'b1110_0101;
    localparam logic [7:0] C_OP_SB  = 8'b1110_1000;
    localparam logic [7:0] C_OP_SH  = 8'b1110_1001;
    localparam logic [7:0] C_OP_SW  = 8'b1110_1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RESP = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] hold_q;
    logic [7:0]  ld_op_q;
    logic [1:0]  ld_off_q;

    logic        is_load, is_store, is_half, is_word;
    logic        misaligned, go, go_load;
    logic [31:0] src;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] ld_result;

    // Decode the M-stage op into access class and size
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_half  = 1'b0;
        is_word  = 1'b0;
        case (op_m)
            C_OP_LB, C_OP_LBU: is_load = 1'b1;
            C_OP_LH, C_OP_LHU: begin is_load = 1'b1; is_half = 1'b1; end
            C_OP_LW:           begin is_load = 1'b1; is_word = 1'b1; end
            C_OP_SB:           is_store = 1'b1;
            C_OP_SH:           begin is_store = 1'b1; is_half = 1'b1; end
            C_OP_SW:           begin is_store = 1'b1; is_word = 1'b1; end
            default: ;
        endcase
    end

    assign misaligned = (is_half & addr_m[0]) | (is_word & (addr_m[1:0] != 2'b00));
    assign adel_m     = ~rst & valid_m & is_load  & misaligned;
    assign ades_m     = ~rst & valid_m & is_store & misaligned;
    assign badvaddr_m = (adel_m | ades_m) ? addr_m : 32'h0;

    // The access fires only on the cycle the instruction actually advances
    assign go      = valid_m & (is_load | is_store) & ~misaligned & ~stall & ~flush;
    assign go_load = go & is_load;

    assign data_sram_en    = go & ~rst;
    assign data_sram_wdata = wdata_m;
    assign data_sram_addr  = (XLATE_EN && addr_m[31:30] == 2'b10) ? (addr_m & UNMAPPED_MASK)
                                                                   : addr_m;

    // Byte write-enables for stores, positioned by the low address bits
    always_comb begin
        data_sram_wen = 4'b0000;
        if (go & is_store & ~rst) begin
            if (is_word)      data_sram_wen = 4'b1111;
            else if (is_half) data_sram_wen = addr_m[1] ? 4'b1100 : 4'b0011;
            else              data_sram_wen = 4'b0001 << addr_m[1:0];
        end
    end

    // Load-response FSM: next-state selection; flush dominates stall
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (go_load) state_d = ST_RESP;
            ST_RESP: begin
                if (flush)        state_d = ST_IDLE;
                else if (stall)   state_d = ST_HOLD;
                else if (go_load) state_d = ST_RESP;
                else              state_d = ST_IDLE;
            end
            ST_HOLD: begin
                if (flush)        state_d = ST_IDLE;
                else if (!stall)  state_d = go_load ? ST_RESP : ST_IDLE;
            end
            default:              state_d = ST_IDLE;
        endcase
    end

    // State, held read data and the load descriptor of the in-flight load
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            hold_q   <= 32'h0;
            ld_op_q  <= 8'h0;
            ld_off_q <= 2'b00;
        end else begin
            state_q <= state_d;
            if (flush)
                hold_q <= 32'h0;
            else if (state_q == ST_RESP && stall)
                hold_q <= data_sram_rdata;
            if (go_load) begin
                ld_op_q  <= op_m;
                ld_off_q <= addr_m[1:0];
            end
        end
    end

    // Select the data source for W and align/extend it per the latched load op
    always_comb begin
        case (state_q)
            ST_RESP: src = data_sram_rdata;
            ST_HOLD: src = hold_q;
            default: src = 32'h0;
        endcase
        sel_byte = src[8*ld_off_q +: 8];
        sel_half = src[16*ld_off_q[1] +: 16];
        case (ld_op_q)
            C_OP_LB:  ld_result = {{24{sel_byte[7]}}, sel_byte};
            C_OP_LBU: ld_result = {24'h0, sel_byte};
            C_OP_LH:  ld_result = {{16{sel_half[15]}}, sel_half};
            C_OP_LHU: ld_result = {16'h0, sel_half};
            C_OP_LW:  ld_result = src;
            default:  ld_result = 32'h0;
        endcase
    end

    assign readdata_w = rst ? 32'h0 : ld_result;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Scoreboard bench for mem_access_unit. Directed cases plus
//               randomized traffic against a transaction-level model of the
//               load/store path and the W-stage result register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

    localparam logic [7:0] LB  = 8'hE0;
    localparam logic [7:0] LH  = 8'hE1;
    localparam logic [7:0] LW  = 8'hE3;
    localparam logic [7:0] LBU = 8'hE4;
    localparam logic [7:0] LHU = 8'hE5;
    localparam logic [7:0] SB  = 8'hE8;
    localparam logic [7:0] SH  = 8'hE9;
    localparam logic [7:0] SW  = 8'hEB;
    localparam logic [7:0] NOP = 8'h21;

    logic        clk = 1'b0;
    logic        rst, stall, flush, valid_m;
    logic [7:0]  op_m;
    logic [31:0] addr_m, wdata_m, data_sram_rdata;
    logic        data_sram_en, adel_m, ades_m;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr, data_sram_wdata, badvaddr_m, readdata_w;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_m(valid_m),
        .op_m(op_m), .addr_m(addr_m), .wdata_m(wdata_m),
        .data_sram_rdata(data_sram_rdata), .data_sram_en(data_sram_en),
        .data_sram_wen(data_sram_wen), .data_sram_addr(data_sram_addr),
        .data_sram_wdata(data_sram_wdata), .adel_m(adel_m), .ades_m(ades_m),
        .badvaddr_m(badvaddr_m), .readdata_w(readdata_w)
    );

    typedef struct {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        adel;
        logic        ades;
        logic [31:0] badv;
        logic [31:0] rd;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Model: a load accepted this cycle delivers a result next cycle; that
    // result stays visible in W while W is stalled, until flush/reset.
    bit          m_pend = 0;
    logic [7:0]  m_op   = 8'h0;
    logic [1:0]  m_off  = 2'b0;
    bit          m_hold = 0;
    logic [31:0] m_hval = 32'h0;

    function automatic logic [31:0] load_value(logic [7:0] op, logic [1:0] off, logic [31:0] word);
        logic [31:0] b, h;
        b = (word >> (8 * off)) & 32'hFF;
        h = (word >> (16 * off[1])) & 32'hFFFF;
        case (op)
            LB:      return (b > 32'h7F) ? (b | 32'hFFFF_FF00) : b;
            LBU:     return b;
            LH:      return (h > 32'h7FFF) ? (h | 32'hFFFF_0000) : h;
            LHU:     return h;
            LW:      return word;
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, push the expected response, advance the model
    task automatic cycle(input logic v, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] wd, input logic st, input logic fl,
                         input logic [31:0] rd, input logic r);
        exp_t e;
        bit   ld, sto, half, word, mis, g;
        @(posedge clk);
        #1;
        valid_m = v; op_m = op; addr_m = a; wdata_m = wd;
        stall = st; flush = fl; data_sram_rdata = rd; rst = r;

        ld   = (op == LB) || (op == LBU) || (op == LH) || (op == LHU) || (op == LW);
        sto  = (op == SB) || (op == SH) || (op == SW);
        half = (op == LH) || (op == LHU) || (op == SH);
        word = (op == LW) || (op == SW);
        mis  = (half && a[0]) || (word && a[1:0] != 2'b00);
        g    = v && (ld || sto) && !mis && !st && !fl && !r;

        e.en    = g;
        e.wen   = 4'b0000;
        if (g && sto) begin
            if (op == SW)      e.wen = 4'b1111;
            else if (op == SH) e.wen = a[1] ? 4'b1100 : 4'b0011;
            else               e.wen = 4'(1 << a[1:0]);
        end
        e.addr  = (a[31:30] == 2'b10) ? (a & 32'h1FFF_FFFF) : a;
        e.wdata = wd;
        e.adel  = !r && v && ld && mis;
        e.ades  = !r && v && sto && mis;
        e.badv  = (e.adel || e.ades) ? a : 32'h0;
        if (r)           e.rd = 32'h0;
        else if (m_pend) e.rd = load_value(m_op, m_off, rd);
        else if (m_hold) e.rd = m_hval;
        else             e.rd = 32'h0;
        exp_q.push_back(e);

        m_hold = !r && !fl && st && (m_pend || m_hold);
        if (m_hold) m_hval = e.rd;
        m_pend = g && ld;
        if (m_pend) begin m_op = op; m_off = a[1:0]; end
    endtask

    // Monitor: compare DUT outputs against the oldest expectation each cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("en",       32'(data_sram_en),  32'(e.en));
                chk("wen",      32'(data_sram_wen), 32'(e.wen));
                chk("addr",     data_sram_addr,     e.addr);
                chk("wdata",    data_sram_wdata,    e.wdata);
                chk("adel",     32'(adel_m),        32'(e.adel));
                chk("ades",     32'(ades_m),        32'(e.ades));
                chk("badvaddr", badvaddr_m,         e.badv);
                chk("readdata", readdata_w,         e.rd);
            end
        end
    end

    initial begin
        logic [7:0] ops [9];
        ops = '{LB, LBU, LH, LHU, LW, SB, SH, SW, NOP};
        rst = 1'b1; stall = 1'b0; flush = 1'b0; valid_m = 1'b0; op_m = 8'h0;
        addr_m = 32'h0; wdata_m = 32'h0; data_sram_rdata = 32'h0;

        cycle(0, NOP, 0, 0, 0, 0, 32'h1234_5678, 1);
        cycle(1, LW, 32'h10, 0, 0, 0, 32'h1234_5678, 1);
        #1; chk("reset_en", 32'(data_sram_en), 32'h0);
        chk("reset_rd", readdata_w, 32'h0);

        // SB byte lane 2
        cycle(1, SB, 32'h0000_0102, 32'hABAB_ABAB, 0, 0, 0, 0);
        #1; chk("sb_en", 32'(data_sram_en), 32'h1);
        chk("sb_wen", 32'(data_sram_wen), 32'h4);

        // LB / LBU at offset 3
        cycle(1, LB, 32'h0000_0203, 0, 0, 0, 0, 0);
        cycle(1, LBU, 32'h0000_0203, 0, 0, 0, 32'h8012_3456, 0);
        #1; chk("lb_sext", readdata_w, 32'hFFFF_FF80);
        cycle(0, NOP, 0, 0, 0, 0, 32'h8012_3456, 0);
        #1; chk("lbu_zext", readdata_w, 32'h0000_0080);

        // Misaligned LH and SW
        cycle(1, LH, 32'h0000_0001, 0, 0, 0, 0, 0);
        #1; chk("lh_adel", 32'(adel_m), 32'h1);
        chk("lh_badv", badvaddr_m, 32'h1);
        cycle(1, SW, 32'h0000_0002, 32'h5555_AAAA, 0, 0, 0, 0);
        #1; chk("sw_ades", 32'(ades_m), 32'h1);
        chk("sw_wen", 32'(data_sram_wen), 32'h0);

        // LW then a three-cycle W stall
        cycle(1, LW, 32'h10, 0, 0, 0, 0, 0);
        cycle(0, NOP, 0, 0, 1, 0, 32'hDEAD_BEEF, 0);
        cycle(0, NOP, 0, 0, 1, 0, 0, 0);
        cycle(0, NOP, 0, 0, 1, 0, 0, 0);
        #1; chk("hold_word", readdata_w, 32'hDEAD_BEEF);
        cycle(0, NOP, 0, 0, 0, 0, 0, 0);
        cycle(0, NOP, 0, 0, 0, 0, 0, 0);
        #1; chk("after_hold", readdata_w, 32'h0);

        // Address translation
        cycle(1, SW, 32'hBFC0_0010, 0, 0, 0, 0, 0);
        #1; chk("kseg1_addr", data_sram_addr, 32'h1FC0_0010);
        cycle(1, SW, 32'h0000_0010, 0, 0, 0, 0, 0);
        #1; chk("kuseg_addr", data_sram_addr, 32'h0000_0010);

        // Reset and flush while holding
        cycle(1, LW, 32'h20, 0, 0, 0, 0, 0);
        cycle(0, NOP, 0, 0, 1, 0, 32'hCAFE_F00D, 0);
        cycle(0, NOP, 0, 0, 1, 0, 0, 1);
        cycle(0, NOP, 0, 0, 1, 0, 0, 0);
        #1; chk("rst_hold_drop", readdata_w, 32'h0);
        cycle(1, LW, 32'h20, 0, 0, 0, 0, 0);
        cycle(0, NOP, 0, 0, 1, 0, 32'hCAFE_F00D, 0);
        cycle(1, LW, 32'h24, 0, 1, 1, 0, 0);
        cycle(0, NOP, 0, 0, 1, 0, 0, 0);
        #1; chk("flush_hold_drop", readdata_w, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a[1:0] = 2'b00;
            cycle($urandom_range(0, 99) < 85, ops[$urandom_range(0, 8)], a, $urandom,
                  $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 8, $urandom,
                  $urandom_range(0, 99) < 2);
        end

        cycle(0, NOP, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
